// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit:
// next-PC source encodings, handler FSM states and default addresses.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_REG    = 2'd3
  } next_sel_e;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC target selection and misalignment detection.
// Ports: i_pc, i_next_sel, i_br_taken, i_imm16, i_jidx, i_reg_target
//        -> o_pc_plus4, o_target, o_misaligned.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [1:0]       i_next_sel,
  input  logic             i_br_taken,
  input  logic [15:0]      i_imm16,
  input  logic [25:0]      i_jidx,
  input  logic [WIDTH-1:0] i_reg_target,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic [WIDTH-1:0] o_target,
  output logic             o_misaligned
);

  logic [WIDTH-1:0] w_br_off;
  next_sel_e        w_sel;

  assign w_sel      = next_sel_e'(i_next_sel);
  assign o_pc_plus4 = i_pc + WIDTH'(4);
  assign w_br_off   = {{(WIDTH-18){i_imm16[15]}}, i_imm16, 2'b00};

  always_comb begin
    o_target     = o_pc_plus4;
    o_misaligned = 1'b0;
    unique case (w_sel)
      SEL_SEQ: o_target = o_pc_plus4;
      SEL_BRANCH: begin
        if (i_br_taken)
          o_target = o_pc_plus4 + w_br_off;
      end
      SEL_JUMP: begin
        // Upper bits above 28 come from pc+4; empty at WIDTH=28.
        o_target[27:0] = {i_jidx, 2'b00};
      end
      SEL_REG: begin
        o_target     = i_reg_target;
        o_misaligned = |i_reg_target[1:0];
      end
      default: o_target = o_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter unit: PC/EPC registers, exception entry/return,
// retired-update counter. Ports: i_clk, i_rst, i_pc_we, i_next_sel,
// i_br_taken, i_imm16, i_jidx, i_reg_target, i_exc_req, i_eret ->
// o_pc, o_pc_plus4, o_epc, o_exl, o_align_fault, o_exc_dropped, o_retired.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int          CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pc_we,
  input  logic [1:0]       i_next_sel,
  input  logic             i_br_taken,
  input  logic [15:0]      i_imm16,
  input  logic [25:0]      i_jidx,
  input  logic [WIDTH-1:0] i_reg_target,
  input  logic             i_exc_req,
  input  logic             i_eret,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic [WIDTH-1:0] o_epc,
  output logic             o_exl,
  output logic             o_align_fault,
  output logic             o_exc_dropped,
  output logic [CNT_W-1:0] o_retired
);

  pc_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_epc, w_epc_nxt;
  logic [CNT_W-1:0] r_retired, w_ret_nxt;
  logic             r_af, w_af_nxt;
  logic             r_dr, w_dr_nxt;

  logic [WIDTH-1:0] w_target;
  logic             w_misaligned;
  logic             w_mis_req;
  logic             w_exc;

  pc_next_mux #(.WIDTH(WIDTH)) u_mux (
    .i_pc         (r_pc),
    .i_next_sel   (i_next_sel),
    .i_br_taken   (i_br_taken),
    .i_imm16      (i_imm16),
    .i_jidx       (i_jidx),
    .i_reg_target (i_reg_target),
    .o_pc_plus4   (o_pc_plus4),
    .o_target     (w_target),
    .o_misaligned (w_misaligned)
  );

  // eret suppresses pc_we, so a simultaneous bad target is not a fault.
  assign w_mis_req = i_pc_we & ~i_eret & w_misaligned;
  assign w_exc     = i_exc_req | w_mis_req;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_ret_nxt   = r_retired;
    w_af_nxt    = 1'b0;
    w_dr_nxt    = 1'b0;
    unique case (r_state)
      ST_NORMAL: begin
        if (w_exc) begin
          w_epc_nxt   = r_pc;
          w_pc_nxt    = EXC_VECTOR[WIDTH-1:0];
          w_state_nxt = ST_HANDLER;
          w_af_nxt    = w_mis_req;
        end else if (i_eret) begin
          w_pc_nxt = r_pc;
        end else if (i_pc_we) begin
          w_pc_nxt  = w_target;
          w_ret_nxt = r_retired + CNT_W'(1);
        end
      end
      ST_HANDLER: begin
        if (w_exc) begin
          w_dr_nxt = 1'b1;
          w_af_nxt = w_mis_req;
        end else if (i_eret) begin
          w_pc_nxt    = r_epc;
          w_state_nxt = ST_NORMAL;
        end else if (i_pc_we) begin
          w_pc_nxt  = w_target;
          w_ret_nxt = r_retired + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_NORMAL;
      r_pc      <= RESET_PC[WIDTH-1:0];
      r_epc     <= '0;
      r_retired <= '0;
      r_af      <= 1'b0;
      r_dr      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_epc     <= w_epc_nxt;
      r_retired <= w_ret_nxt;
      r_af      <= w_af_nxt;
      r_dr      <= w_dr_nxt;
    end
  end

  assign o_pc          = r_pc;
  assign o_epc         = r_epc;
  assign o_exl         = (r_state == ST_HANDLER);
  assign o_align_fault = r_af;
  assign o_exc_dropped = r_dr;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: a 32-bit build and a 28-bit build
// with a 4-bit counter, both driven identically and checked against a model.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, pc_we, br_taken, exc_req, eret;
  logic [1:0]  next_sel;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic [31:0] reg_target;

  logic [31:0] pc_a, p4_a, epc_a, ret_a;
  logic        exl_a, af_a, dr_a;
  logic [27:0] pc_b, p4_b, epc_b;
  logic [3:0]  ret_b;
  logic        exl_b, af_b, dr_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_ctrl #(.WIDTH(32), .CNT_W(32)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_pc_we(pc_we), .i_next_sel(next_sel),
    .i_br_taken(br_taken), .i_imm16(imm16), .i_jidx(jidx),
    .i_reg_target(reg_target), .i_exc_req(exc_req), .i_eret(eret),
    .o_pc(pc_a), .o_pc_plus4(p4_a), .o_epc(epc_a), .o_exl(exl_a),
    .o_align_fault(af_a), .o_exc_dropped(dr_a), .o_retired(ret_a)
  );

  pc_ctrl #(.WIDTH(28), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pc_we(pc_we), .i_next_sel(next_sel),
    .i_br_taken(br_taken), .i_imm16(imm16), .i_jidx(jidx),
    .i_reg_target(reg_target[27:0]), .i_exc_req(exc_req), .i_eret(eret),
    .o_pc(pc_b), .o_pc_plus4(p4_b), .o_epc(epc_b), .o_exl(exl_b),
    .o_align_fault(af_b), .o_exc_dropped(dr_b), .o_retired(ret_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    bit          exl;
    logic [31:0] ret;
    bit          af;
    bit          dr;
  } mdl_t;

  mdl_t ma, mb;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference behaviour, applied once per rising edge.
  function automatic mdl_t mstep(input mdl_t m, input int w, input int cw);
    logic [31:0] msk, p4, t, off;
    bit          mis;
    mdl_t        n;
    msk = mask_of(w);
    p4  = (m.pc + 32'd4) & msk;
    off = {{14{imm16[15]}}, imm16, 2'b00};
    case (next_sel)
      2'd0:    t = p4;
      2'd1:    t = br_taken ? ((p4 + off) & msk) : p4;
      2'd2:    t = ((p4 & 32'hF000_0000) | ({6'd0, jidx} << 2)) & msk;
      default: t = reg_target & msk;
    endcase
    mis = pc_we && !eret && (t % 4 != 0);
    n = m;
    n.af = 0;
    n.dr = 0;
    if (rst) begin
      n.pc = 32'h0000_3000 & msk;
      n.epc = 0;
      n.exl = 0;
      n.ret = 0;
    end else if (exc_req || mis) begin
      n.af = mis;
      if (!m.exl) begin
        n.epc = m.pc;
        n.pc  = 32'h0000_4180 & msk;
        n.exl = 1;
      end else begin
        n.dr = 1;
      end
    end else if (eret) begin
      if (m.exl) begin
        n.pc  = m.epc;
        n.exl = 0;
      end
    end else if (pc_we) begin
      n.pc  = t;
      n.ret = (m.ret + 32'd1) & mask_of(cw);
    end
    return n;
  endfunction

  task automatic compare_all();
    chk("pc_a", pc_a, ma.pc);
    chk("p4_a", p4_a, ma.pc + 32'd4);
    chk("epc_a", epc_a, ma.epc);
    chk("exl_a", {31'd0, exl_a}, {31'd0, ma.exl});
    chk("af_a", {31'd0, af_a}, {31'd0, ma.af});
    chk("dr_a", {31'd0, dr_a}, {31'd0, ma.dr});
    chk("ret_a", ret_a, ma.ret);
    chk("pc_b", {4'd0, pc_b}, mb.pc);
    chk("p4_b", {4'd0, p4_b}, (mb.pc + 32'd4) & mask_of(28));
    chk("epc_b", {4'd0, epc_b}, mb.epc);
    chk("exl_b", {31'd0, exl_b}, {31'd0, mb.exl});
    chk("af_b", {31'd0, af_b}, {31'd0, mb.af});
    chk("dr_b", {31'd0, dr_b}, {31'd0, mb.dr});
    chk("ret_b", {28'd0, ret_b}, mb.ret);
  endtask

  task automatic step(input bit r, input bit we, input logic [1:0] sel,
                      input bit bt, input logic [15:0] imm,
                      input logic [25:0] ji, input logic [31:0] rt,
                      input bit ex, input bit er);
    rst = r; pc_we = we; next_sel = sel; br_taken = bt;
    imm16 = imm; jidx = ji; reg_target = rt; exc_req = ex; eret = er;
    @(posedge clk);
    ma = mstep(ma, 32, 32);
    mb = mstep(mb, 28, 4);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic seq();
    step(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    rst = 1; pc_we = 0; next_sel = 0; br_taken = 0;
    imm16 = 0; jidx = 0; reg_target = 0; exc_req = 0; eret = 0;
    @(negedge clk);

    do_reset();
    chk("rst_pc", pc_a, 32'h3000);
    seq(); seq(); seq();
    chk("seq3_pc", pc_a, 32'h300C);
    chk("seq3_ret", ret_a, 32'd3);

    do_reset();
    step(0, 1, 2'd1, 1, 16'hFFFF, 0, 0, 0, 0);
    chk("br_back", pc_a, 32'h3000);
    step(0, 1, 2'd1, 0, 16'hFFFF, 0, 0, 0, 0);
    chk("br_nt", pc_a, 32'h3004);
    step(0, 1, 2'd2, 0, 0, 26'h0000C40, 0, 0, 0);
    chk("jump", pc_a, 32'h3100);
    step(0, 1, 2'd3, 0, 0, 0, 32'h2000_0000, 0, 0);
    chk("jr", pc_a, 32'h2000_0000);

    do_reset(); seq(); seq();
    step(0, 1, 2'd3, 0, 0, 0, 32'h3011, 0, 0);
    chk("mis_af", {31'd0, af_a}, 32'd1);
    chk("mis_epc", epc_a, 32'h3008);
    chk("mis_pc", pc_a, 32'h4180);
    chk("mis_ret", ret_a, 32'd2);
    step(0, 0, 2'd0, 0, 0, 0, 0, 1, 0);
    chk("drop", {31'd0, dr_a}, 32'd1);
    chk("drop_pc", pc_a, 32'h4180);
    step(0, 1, 2'd0, 0, 0, 0, 0, 0, 1);
    chk("eret_pc", pc_a, 32'h3008);
    chk("eret_exl", {31'd0, exl_a}, 32'd0);
    step(0, 0, 2'd0, 0, 0, 0, 0, 1, 0);
    do_reset();
    chk("rst_hnd_epc", epc_a, 32'd0);

    for (int i = 0; i < 16; i++) seq();
    chk("wrap4", {28'd0, ret_b}, 32'd0);
    chk("nowrap32", ret_a, 32'd16);

    for (int i = 0; i < 3000; i++) begin
      bit          r, we, ex, er, bt;
      logic [1:0]  sel;
      logic [31:0] rt;
      r   = ($urandom_range(0, 99) < 2);
      we  = ($urandom_range(0, 99) < 60);
      ex  = ($urandom_range(0, 99) < 6);
      er  = ($urandom_range(0, 99) < 12);
      bt  = $urandom_range(0, 1) == 1;
      sel = 2'($urandom_range(0, 3));
      rt  = $urandom;
      if (($urandom_range(0, 99) < 75) || (er && we)) rt[1:0] = 2'b00;
      step(r, we, sel, bt, 16'($urandom), 26'($urandom), rt, ex, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter unit for the multicycle datapath, replacing the plain loadable PC register. It holds the PC, computes the next PC internally (sequential, branch, jump, register), handles exception entry and return with an EPC register and an exception-level flag, and detects misaligned targets. It sits in the fetch stage and is written only in the cycles the control FSM asserts `pc_we`, `exc_req` or `eret`.

## Interface
- `WIDTH`, 32, PC/EPC width; legal range 28..32
- `RESET_PC`, 32'h0000_3000, PC value after reset
- `EXC_VECTOR`, 32'h0000_4180, exception handler entry address
- `CNT_W`, 32, width of the retired-update counter
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc_we`  in  1  commit a normal next-PC update this cycle
- `next_sel`  in  2  0 SEQ, 1 BRANCH, 2 JUMP, 3 REG
- `br_taken`  in  1  branch condition; with BRANCH, 0 behaves as SEQ
- `imm16`  in  16  branch offset in words
- `jidx`  in  26  jump index
- `reg_target`  in  WIDTH  jr/jalr target
- `exc_req`  in  1  external exception request (one-cycle pulse)
- `eret`  in  1  return from exception
- `pc`  out  WIDTH  current PC, registered
- `pc_plus4`  out  WIDTH  `pc + 4`, combinational
- `epc`  out  WIDTH  saved exception PC, registered
- `exl`  out  1  exception level; 1 while inside a handler
- `align_fault`  out  1  one-cycle pulse, misaligned target detected
- `exc_dropped`  out  1  one-cycle pulse, exception ignored because `exl`=1
- `retired`  out  CNT_W  count of committed normal updates

## Operation
- Target computation, all modulo 2^WIDTH:
  - SEQ = `pc_plus4`.
  - BRANCH = `pc_plus4 + (sext(imm16) << 2)` when `br_taken`, else `pc_plus4`.
  - JUMP = `{pc_plus4[WIDTH-1:28], jidx, 2'b00}`, truncated to WIDTH; for WIDTH=28 the upper field is empty.
  - REG = `reg_target`.
- Misaligned: target bits [1:0] ≠ 0. Only REG can produce this; the other sources are aligned by construction.
- Per-edge priority, highest first:
  1. `rst`: `pc`=RESET_PC, `epc`=0, `exl`=0, `retired`=0, both pulse outputs 0.
  2. Exception entry. Raised by `exc_req`, or by `pc_we` with a misaligned target; acts only when `exl`=0. Effect: `epc`←`pc`, `pc`←EXC_VECTOR, `exl`←1. A misaligned cause also pulses `align_fault` and does not increment `retired`.
  3. Exception while `exl`=1: `pc`, `epc` and `exl` are unchanged and `exc_dropped` pulses. A misaligned cause also pulses `align_fault`. Any `pc_we` or `eret` in the same cycle is ignored.
  4. `eret` with `exl`=1: `pc`←`epc`, `exl`←0. `eret` with `exl`=0 has no effect.
  5. `pc_we` with an aligned target: `pc`←target, `retired`+1, wrapping at 2^CNT_W.
  6. Otherwise hold.
- When `eret` and `pc_we` are asserted together, `eret` wins and `pc_we` is ignored.
- Two-state FSM encoded in `exl`: NORMAL (exl=0) → HANDLER on exception entry; HANDLER → NORMAL on `eret`.

## Timing
- Each update is visible on `pc` the cycle after the enabling edge; `pc_plus4` follows `pc` combinationally in the same cycle.
- `align_fault` and `exc_dropped` are registered and high for exactly the one cycle after the triggering edge.
- Reset mid-handler clears `exl` and `epc` on that edge. No pending exception survives reset.
- No simulation-only output (`$display`) in synthesisable RTL.

## Structure
- Shared package `pc_pkg`:
  - `next_sel` encodings SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_REG.
  - Default RESET_PC and EXC_VECTOR constants.
- Sub-module `pc_next_mux`: purely combinational target and misalignment computation.
- `pc_ctrl` holds the registers, the priority logic and the counter.

## Test plan
- Reset, then 3× `pc_we` SEQ → `pc` = 0x3000, 0x3004, 0x3008, 0x300C; `retired` = 3.
- At 0x3000, BRANCH with `imm16`=0xFFFF and `br_taken`=1 → `pc`=0x3000. Same with `br_taken`=0 → `pc`=0x3004.
- At 0x3004, JUMP with `jidx`=0x0000C40 → `pc`=0x3100. Then REG with `reg_target`=0x2000_0000 → `pc`=0x2000_0000.
- At 0x3008, REG with `reg_target`=0x3011 → one-cycle `align_fault`, `epc`=0x3008, `pc`=0x4180, `exl`=1, `retired` unchanged.
- In handler: `exc_req` → `exc_dropped` pulse, `pc` unchanged. Then `eret` with `pc_we` asserted the same cycle → `pc`=`epc`, `exl`=0.
- `rst` while `exl`=1 → next cycle `pc`=0x3000, `epc`=0, `exl`=0. A `CNT_W`=4 build wraps `retired` from 15 to 0.
